serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock, WIDTH-cycle latency.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic             borrow_q, borrow_d, bout_q, bout_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
    logic             ai, bi, diff, nborrow, last;
    logic [WIDTH-1:0] full;

    assign ai      = a_q[cnt_q];
    assign bi      = b_q[cnt_q];
    assign diff    = ai ^ bi ^ borrow_q;
    assign nborrow = (~ai & bi) | (~(ai ^ bi) & borrow_q);
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign full    = {diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d      = a;
                b_d      = b;
                borrow_d = bin;
                cnt_d    = '0;
                res_d    = '0;
                busy_d   = 1'b1;
                state_d  = SHIFT;
            end
        end else begin
            res_d    = full;
            borrow_d = nborrow;
            cnt_d    = last ? cnt_q : cnt_q + CW'(1);
            if (last) begin
                d_d     = full;
                bout_d  = nborrow;
                zero_d  = full == '0;
                ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven vectors plus handshake and reset sequences.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n, start, bin;
    logic [7:0] a, b;
    logic [7:0] d;
    logic       bout, zero, ovf, busy, done;
    int         total = 0;
    int         bad = 0;
    int         lat;

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bout, zero, ovf;
    } vec_t;

    vec_t vecs[7];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .d(d), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        a = ta;
        b = tb;
        bin = tbin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        do begin
            @(posedge clk);
            #1 l++;
        end while (!done && l < 20);
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        bin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {d, bout, zero, ovf, busy, done}, '0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            chk($sformatf("v%0d_busy", i), busy, 1'b1);
            chk($sformatf("v%0d_quiet_outputs", i), done, 1'b0);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_d", i), d, vecs[i].d);
            chk($sformatf("v%0d_flags", i), {bout, zero, ovf, busy}, {vecs[i].bout, vecs[i].zero, vecs[i].ovf, 1'b0});
        end
        // done must last one cycle and results must hold while idle
        @(posedge clk);
        #1;
        chk("done_single_cycle", done, 1'b0);
        chk("hold_d", d, 8'hFF);
        // start pulsed mid-operation with other operands is ignored
        start_op(8'h05, 8'h03, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_during_shift", d, 8'hFF);
        start_op(8'hFF, 8'h00, 1'b1);
        wait_done(lat);
        chk("ignore_start_latency", lat, 4);
        chk("ignore_start_d", d, 8'h02);
        // back-to-back: start in the done cycle
        start_op(8'h03, 8'h05, 1'b0);
        wait_done(lat);
        chk("b2b_first_d", d, 8'hFE);
        start_op(8'h09, 8'h04, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_done(lat);
        chk("b2b_latency", lat, 8);
        chk("b2b_second_d", d, 8'h05);
        // reset on the 4th SHIFT edge aborts
        @(posedge clk);
        #1;
        start_op(8'h03, 8'h05, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_outputs", {d, bout, zero, ovf, busy, done}, '0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_ignored_in_reset", busy, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        lat = 0;
        repeat (12) begin
            @(posedge clk);
            #1 lat += done;
        end
        chk("abort_no_done", lat, 0);
        start_op(8'h09, 8'h04, 1'b0);
        wait_done(lat);
        chk("after_reset_latency", lat, 8);
        chk("after_reset_d", {d, bout, zero, ovf}, {8'h05, 3'b000});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
